analog_ctrl: RTL and testbench
==============================

# analog_ctrl

Digital sequencer that sits directly upstream/downstream of the analog filter core of each cochlea channel. It generates the core's switched-capacitor clock (`cclk`), its half-rate companion (`div2`) and the mixer local oscillator (`lo`). It resynchronises the comparator decision (`comp_high`) on the core's `phi1b_dig` strobe, and drives it back as filter feedback (`fb`). Every change in comparator decision is logged as an event into a 4-deep FIFO that the digital back-end drains through a valid/ready handshake.

## Interface
Parameters:
- `DIV_W`, 8: width of the `cclk` half-period setting.
- `LO_W`, 8: width of the `lo` half-period setting.
- `TS_W`, 12: width of the sample-index timestamp.

Ports:
- `clk`  in  1  system clock; all state on its rising edge.
- `rstb`  in  1  asynchronous, active-low reset.
- `en`  in  1  channel enable (synchronous).
- `cclk_half`  in  DIV_W  `cclk` half-period minus 1, in `clk` cycles.
- `lo_half`  in  LO_W  `lo` half-period minus 1, in `clk` cycles.
- `cclk`, `div2`, `lo`  out  1 each  to analog core.
- `fb`  out  1  registered comparator decision, fed back to core.
- `comp_high`  in  1  comparator output (asynchronous to `clk`).
- `phi1b_dig`  in  1  core sample strobe (asynchronous to `clk`).
- `evt_valid`  out  1  FIFO non-empty.
- `evt_ready`  in  1  consumer accepts head entry.
- `evt_pol`  out  1  head entry polarity (new `fb` value).
- `evt_ts`  out  TS_W  head entry timestamp.
- `evt_ovf`  out  1  sticky overflow flag.
- `ovf_clr`  in  1  clears `evt_ovf`.

## Operation
- **Reset (`rstb`=0):** every register and every output is 0, including all counters, FIFO pointers and the sync chain.
- **`en`=0:**
  - Divider counters, `cclk`, `div2`, `lo` and the timestamp are held at 0.
  - Sample strobes are ignored.
  - The FIFO keeps its contents and stays readable.
- **`cclk` divider:**
  - The counter runs 0..`cclk_half`; on wrap it returns to 0 and `cclk` toggles.
  - The period is 2·(`cclk_half`+1) `clk` cycles. `cclk_half`=0 gives `clk`/2.
  - A new `cclk_half` value takes effect at the next compare; it is compared live.
  - `div2` toggles on every 0→1 transition of `cclk`.
- **`lo` divider:** independent counter, same rule, using `lo_half`.
- **Sync:**
  - `comp_high` and `phi1b_dig` each pass through a 2-flop synchroniser.
  - A third flop on `phi1b_dig` gives edge detect: `strobe` = prev & ~synced (falling edge).
- **On `strobe` with `en`=1:**
  - `fb` ← synced comp.
  - `ts` increments; it wraps modulo 2^TS_W.
  - If synced comp ≠ `fb`, an event {pol = synced comp, ts = pre-increment value} is pushed.
- **FIFO:**
  - Depth 4; output is the head entry, driven from registers.
  - Pop occurs when `evt_valid`&`evt_ready`.
  - Push when full and no pop: the entry is dropped and `evt_ovf` ← 1.
  - Push and pop in the same cycle when full: both succeed, no drop.
  - Push while empty: `evt_valid` rises the next cycle (no bypass).
  - `ovf_clr` clears `evt_ovf`. If a drop occurs in the same cycle, set wins.

## Timing
- `phi1b_dig` falling at the pin before edge N: `strobe` is high in the cycle after edge N+1, and `fb` and the FIFO push update at edge N+2.
- `comp_high` must be stable ≥3 `clk` cycles before `phi1b_dig` falls.
- `cclk`, `div2`, `lo` and `fb` are direct flop outputs, with no combinational path from inputs.
- `evt_valid`, `evt_pol` and `evt_ts` change only on `clk` edges. Once `evt_valid` is high, the head entry is held until popped.
- `en` falling mid-period: counters and outputs go to 0 at the next edge. `en` rising restarts the period from count 0 with `cclk`=0.

## Configuration
- `ANALOG_CTRL_TS_EN` defined: the timestamp counter and the FIFO `ts` field are implemented as above.
- Not defined:
  - The counter and field are removed.
  - `evt_ts` is tied to 0.
  - The FIFO stores polarity only.
  - All other behaviour is identical.

## Test plan
- **Reset/idle:** `rstb` low, then released with `en`=0 → all outputs are 0; `cclk` stays 0 for 100 cycles.
- **Dividers:**
  - `en`=1, `cclk_half`=3 → `cclk` period is 8 cycles and `div2` period is 16 cycles.
  - `lo_half`=0 → `lo` period is 2 cycles.
  - Change `cclk_half` to 1 mid-period → the new period is 4 cycles after the next wrap.
- **Feedback latency:** `comp_high`=1 settled, then `phi1b_dig` falls before edge N → `fb`=1 at edge N+2, one event pushed {1, ts=0}, `ts`=1.
- **No-change strobe:** a second strobe with `comp_high` still 1 → `fb` stays 1, no push, `ts`=2.
- **FIFO full/overflow:**
  - `evt_ready`=0, 5 alternating decisions → 4 entries are held and `evt_ovf`=1.
  - Drain with `evt_ready`=1 → pols 1,0,1,0 in order with increasing `ts`.
  - `ovf_clr` → `evt_ovf`=0.
- **Simultaneous/reset mid-run:**
  - FIFO full, pop and push in the same cycle → count stays 4, `evt_ovf` stays 0.
  - Assert `rstb` mid-`cclk` period → all outputs 0 immediately and the FIFO is empty.

Source files
------------

// File: rtl/analog_ctrl.sv
// rtl/analog_ctrl.sv - clock sequencer, comparator feedback and event FIFO for one cochlea channel
//
// Purpose: generates cclk/div2/lo for the analog filter core, resynchronises
// the comparator decision on the falling edge of phi1b_dig, feeds it back as
// fb and logs every decision change into a 4-deep event FIFO.
//
// Ports:
//   clk, rstb             system clock, asynchronous active-low reset
//   en                    channel enable (synchronous)
//   cclk_half, lo_half    divider half-period minus 1, in clk cycles
//   cclk, div2, lo        clock outputs to the analog core (flop outputs)
//   comp_high, phi1b_dig  comparator decision and sample strobe (asynchronous)
//   fb                    registered comparator decision back to the core
//   evt_valid/evt_ready   event FIFO handshake; evt_pol/evt_ts is the head entry
//   evt_ovf, ovf_clr      sticky overflow flag and its clear
//
// Build option: define ANALOG_CTRL_TS_EN to implement the sample-index
// timestamp; otherwise entries carry polarity only and evt_ts is tied to 0.

module analog_ctrl #(
  parameter int DIV_W = 8,
  parameter int LO_W  = 8,
  parameter int TS_W  = 12
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             en,
  input  logic [DIV_W-1:0] cclk_half,
  input  logic [LO_W-1:0]  lo_half,
  output logic             cclk,
  output logic             div2,
  output logic             lo,
  output logic             fb,
  input  logic             comp_high,
  input  logic             phi1b_dig,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic             evt_pol,
  output logic [TS_W-1:0]  evt_ts,
  output logic             evt_ovf,
  input  logic             ovf_clr
);

`ifdef ANALOG_CTRL_TS_EN
  localparam int ENT_W = TS_W + 1;
`else
  localparam int ENT_W = 1;
`endif

  // ---------------------------------------------------------------------
  // Synchronisers; the third phi flop provides falling-edge detection.
  // ---------------------------------------------------------------------
  logic comp_s1, comp_s2;
  logic phi_s1, phi_s2, phi_s3;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      comp_s1 <= 1'b0;
      comp_s2 <= 1'b0;
      phi_s1  <= 1'b0;
      phi_s2  <= 1'b0;
      phi_s3  <= 1'b0;
    end else begin
      comp_s1 <= comp_high;
      comp_s2 <= comp_s1;
      phi_s1  <= phi1b_dig;
      phi_s2  <= phi_s1;
      phi_s3  <= phi_s2;
    end
  end

  logic strobe, sample;
  assign strobe = phi_s3 & ~phi_s2;
  assign sample = strobe & en;

  // ---------------------------------------------------------------------
  // cclk divider. The compare is >= so that lowering cclk_half below the
  // current count wraps at once instead of running the counter round.
  // ---------------------------------------------------------------------
  logic [DIV_W-1:0] cclk_cnt;
  logic             cclk_wrap;
  assign cclk_wrap = (cclk_cnt >= cclk_half);

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      cclk_cnt <= '0;
      cclk     <= 1'b0;
      div2     <= 1'b0;
    end else if (!en) begin
      cclk_cnt <= '0;
      cclk     <= 1'b0;
      div2     <= 1'b0;
    end else if (cclk_wrap) begin
      cclk_cnt <= '0;
      cclk     <= ~cclk;
      // cclk is about to go 0->1: that is the div2 toggle point
      if (!cclk) div2 <= ~div2;
    end else begin
      cclk_cnt <= cclk_cnt + DIV_W'(1);
    end
  end

  // ---------------------------------------------------------------------
  // lo divider, independent of cclk
  // ---------------------------------------------------------------------
  logic [LO_W-1:0] lo_cnt;
  logic            lo_wrap;
  assign lo_wrap = (lo_cnt >= lo_half);

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      lo_cnt <= '0;
      lo     <= 1'b0;
    end else if (!en) begin
      lo_cnt <= '0;
      lo     <= 1'b0;
    end else if (lo_wrap) begin
      lo_cnt <= '0;
      lo     <= ~lo;
    end else begin
      lo_cnt <= lo_cnt + LO_W'(1);
    end
  end

  // ---------------------------------------------------------------------
  // Feedback flop and event generation
  // ---------------------------------------------------------------------
  logic push_req;
  assign push_req = sample & (comp_s2 != fb);

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb)       fb <= 1'b0;
    else if (sample) fb <= comp_s2;
  end

  logic [ENT_W-1:0] entry;

`ifdef ANALOG_CTRL_TS_EN
  logic [TS_W-1:0] ts;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb)       ts <= '0;
    else if (!en)    ts <= '0;
    else if (sample) ts <= ts + TS_W'(1);
  end

  // event carries the pre-increment sample index
  assign entry = {comp_s2, ts};
`else
  assign entry = comp_s2;
`endif

  // ---------------------------------------------------------------------
  // 4-deep event FIFO. A push into a full FIFO succeeds only when the head
  // is popped in the same cycle; otherwise it is dropped and flagged.
  // ---------------------------------------------------------------------
  logic [ENT_W-1:0] mem [4];
  logic [1:0]       wr_ptr, rd_ptr;
  logic [2:0]       count;
  logic             full, pop, push, drop;

  assign full = (count == 3'd4);
  assign pop  = evt_valid & evt_ready;
  assign push = push_req & (~full | pop);
  assign drop = push_req & full & ~pop;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      for (int i = 0; i < 4; i++) mem[i] <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      evt_ovf <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= entry;
        wr_ptr      <= wr_ptr + 2'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
      // a drop in the same cycle as a clear leaves the flag set
      if (drop)         evt_ovf <= 1'b1;
      else if (ovf_clr) evt_ovf <= 1'b0;
    end
  end

  logic [ENT_W-1:0] head;
  assign head      = mem[rd_ptr];
  assign evt_valid = (count != 3'd0);
  assign evt_pol   = head[ENT_W-1];

`ifdef ANALOG_CTRL_TS_EN
  assign evt_ts = head[TS_W-1:0];
`else
  assign evt_ts = '0;
`endif

endmodule

// File: tb/tb_analog_ctrl.sv
// tb/tb_analog_ctrl.sv - directed self-checking bench for analog_ctrl

module tb_analog_ctrl;

  localparam int DIV_W = 8;
  localparam int LO_W  = 8;
  localparam int TS_W  = 12;

`ifdef ANALOG_CTRL_TS_EN
  localparam bit TS_ON = 1'b1;
`else
  localparam bit TS_ON = 1'b0;
`endif

  logic             clk;
  logic             rstb;
  logic             en;
  logic [DIV_W-1:0] cclk_half;
  logic [LO_W-1:0]  lo_half;
  logic             cclk, div2, lo, fb;
  logic             comp_high, phi1b_dig;
  logic             evt_valid, evt_ready, evt_pol;
  logic [TS_W-1:0]  evt_ts;
  logic             evt_ovf, ovf_clr;

  int vectors     = 0;
  int miscompares = 0;

  analog_ctrl #(.DIV_W(DIV_W), .LO_W(LO_W), .TS_W(TS_W)) dut (
    .clk       (clk),
    .rstb      (rstb),
    .en        (en),
    .cclk_half (cclk_half),
    .lo_half   (lo_half),
    .cclk      (cclk),
    .div2      (div2),
    .lo        (lo),
    .fb        (fb),
    .comp_high (comp_high),
    .phi1b_dig (phi1b_dig),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_pol   (evt_pol),
    .evt_ts    (evt_ts),
    .evt_ovf   (evt_ovf),
    .ovf_clr   (ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [TS_W-1:0] ets(input int v);
    return TS_ON ? TS_W'(v) : '0;
  endfunction

  function automatic logic pick(input int sel);
    case (sel)
      0:       return cclk;
      1:       return div2;
      default: return lo;
    endcase
  endfunction

  // cycles between two consecutive rising edges of the selected clock, -1 on timeout
  task automatic period_of(input int sel, output int per);
    int   first;
    logic prev, cur;
    first = -1;
    per   = -1;
    prev  = pick(sel);
    for (int i = 0; i < 200; i++) begin
      tick(1);
      cur = pick(sel);
      if (cur && !prev) begin
        if (first < 0) first = i;
        else begin
          per = i - first;
          break;
        end
      end
      prev = cur;
    end
  endtask

  // full sample: settle comp, drop phi, let fb/FIFO update, raise phi again
  task automatic do_strobe(input logic c);
    comp_high = c;
    tick(4);
    phi1b_dig = 1'b0;
    tick(3);
    phi1b_dig = 1'b1;
    tick(3);
  endtask

  task automatic pop_one();
    evt_ready = 1'b1;
    tick(1);
    evt_ready = 1'b0;
  endtask

  // drain four entries with alternating polarity starting at pol0 and consecutive ts
  task automatic drain4(input string tag, input logic pol0, input int ts0);
    evt_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk({tag, "_valid"}, evt_valid, 1'b1);
      chk({tag, "_pol"}, evt_pol, pol0 ^ i[0]);
      chk({tag, "_ts"}, evt_ts, ets(ts0 + i));
      tick(1);
    end
    evt_ready = 1'b0;
    chk({tag, "_empty"}, evt_valid, 1'b0);
  endtask

  initial begin
    int   per;
    logic cclk_seen;

    rstb      = 1'b0;
    en        = 1'b0;
    cclk_half = 8'd3;
    lo_half   = 8'd0;
    comp_high = 1'b0;
    phi1b_dig = 1'b1;
    evt_ready = 1'b0;
    ovf_clr   = 1'b0;

    // reset and idle
    tick(3);
    chk("reset_outputs", {cclk, div2, lo, fb, evt_valid, evt_pol, evt_ovf, evt_ts}, '0);
    rstb = 1'b1;
    cclk_seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      cclk_seen |= cclk;
    end
    chk("idle_cclk_never_high", cclk_seen, 1'b0);
    chk("idle_outputs", {cclk, div2, lo, fb, evt_valid, evt_pol, evt_ovf, evt_ts}, '0);

    // dividers: cclk_half=3 first rises on the 4th edge after en
    en = 1'b1;
    tick(3);
    chk("cclk_before_first_wrap", cclk, 1'b0);
    tick(1);
    chk("cclk_first_rise", cclk, 1'b1);
    chk("div2_first_rise", div2, 1'b1);
    chk("lo_phase", lo, 1'b0);
    period_of(0, per);
    chk("cclk_period_8", per, 8);
    period_of(1, per);
    chk("div2_period_16", per, 16);
    period_of(2, per);
    chk("lo_period_2", per, 2);
    cclk_half = 8'd1;
    period_of(0, per);
    chk("cclk_period_4_after_change", per, 4);

    // en falling mid-period clears the dividers at the next edge
    for (int i = 0; i < 10 && !cclk; i++) tick(1);
    chk("cclk_high_before_disable", cclk, 1'b1);
    en = 1'b0;
    tick(1);
    chk("disable_clears_clocks", {cclk, div2, lo}, 3'b000);

    // en rising restarts from count 0 with cclk low
    cclk_half = 8'd3;
    en = 1'b1;
    tick(3);
    chk("restart_cclk_low", cclk, 1'b0);
    tick(1);
    chk("restart_cclk_rise", cclk, 1'b1);

    // feedback latency: phi falls before edge N, fb updates at N+2
    comp_high = 1'b1;
    tick(4);
    phi1b_dig = 1'b0;
    tick(2);
    chk("fb_not_yet_at_n1", fb, 1'b0);
    chk("fifo_empty_at_n1", evt_valid, 1'b0);
    tick(1);
    chk("fb_at_n2", fb, 1'b1);
    chk("evt1_valid", evt_valid, 1'b1);
    chk("evt1_pol", evt_pol, 1'b1);
    chk("evt1_ts", evt_ts, ets(0));
    phi1b_dig = 1'b1;
    tick(3);

    // no-change strobe: no push, ts still advances
    do_strobe(1'b1);
    chk("nochange_fb", fb, 1'b1);
    chk("nochange_head_pol", evt_pol, 1'b1);
    pop_one();
    chk("nochange_no_push", evt_valid, 1'b0);
    do_strobe(1'b0);
    chk("change_fb", fb, 1'b0);
    chk("evt2_pol", evt_pol, 1'b0);
    chk("evt2_ts_after_two_samples", evt_ts, ets(2));
    pop_one();
    chk("evt2_popped", evt_valid, 1'b0);

    // overflow: five changes into a non-draining FIFO
    do_strobe(1'b1);
    do_strobe(1'b0);
    do_strobe(1'b1);
    do_strobe(1'b0);
    chk("full_no_ovf", evt_ovf, 1'b0);
    do_strobe(1'b1);
    chk("fifth_push_ovf", evt_ovf, 1'b1);
    chk("full_head_held", evt_pol, 1'b1);
    drain4("ovf_drain", 1'b1, 3);
    chk("ovf_sticky", evt_ovf, 1'b1);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    chk("ovf_cleared", evt_ovf, 1'b0);

    // full FIFO with push and pop on the same edge
    do_strobe(1'b0);
    do_strobe(1'b1);
    do_strobe(1'b0);
    do_strobe(1'b1);
    comp_high = 1'b0;
    tick(4);
    phi1b_dig = 1'b0;
    tick(2);
    evt_ready = 1'b1;
    tick(1);
    evt_ready = 1'b0;
    phi1b_dig = 1'b1;
    chk("simul_fb", fb, 1'b0);
    chk("simul_no_ovf", evt_ovf, 1'b0);
    tick(3);
    drain4("simul_drain", 1'b1, 9);

    // asynchronous reset mid-period with an entry pending
    do_strobe(1'b1);
    chk("pre_reset_valid", evt_valid, 1'b1);
    for (int i = 0; i < 10 && !cclk; i++) tick(1);
    chk("pre_reset_cclk_high", cclk, 1'b1);
    rstb = 1'b0;
    #1;
    chk("async_reset_outputs", {cclk, div2, lo, fb, evt_valid, evt_pol, evt_ovf, evt_ts}, '0);
    tick(2);
    rstb = 1'b1;
    tick(1);
    chk("post_reset_fifo_empty", evt_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
